// File: rtl/qproc_inport_pkg.sv
// Shared types and constants for the processor input-port read engine.
package qproc_inport_pkg;

    localparam int PORT_IDX_W = 4;

    localparam logic INRD_IMM  = 1'b0;
    localparam logic INRD_WAIT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } inrd_st_t;

    typedef struct packed {
        logic is_new;
        logic tmo;
        logic err;
    } inrd_flags_t;

    function automatic inrd_flags_t mk_flags(input logic is_new, input logic tmo, input logic err);
        inrd_flags_t f;
        f.is_new = is_new;
        f.tmo    = tmo;
        f.err    = err;
        return f;
    endfunction

endpackage

// File: rtl/qproc_inport_rd_if.sv
// Core-side request/response bus of the input-port read engine.
interface qproc_inport_rd_if #(
    parameter int TMO_W = 16
);
    import qproc_inport_pkg::*;

    logic                  rd_req_i;
    logic [PORT_IDX_W-1:0] rd_port_i;
    logic                  rd_mode_i;
    logic [TMO_W-1:0]      rd_tmo_i;
    logic                  rd_abort_i;
    logic                  busy_o;
    logic                  rd_ack_o;
    logic [63:0]           rd_data_o;
    logic                  rd_new_o;
    logic                  rd_tmo_o;
    logic                  rd_err_o;

    modport slave (
        input  rd_req_i, rd_port_i, rd_mode_i, rd_tmo_i, rd_abort_i,
        output busy_o, rd_ack_o, rd_data_o, rd_new_o, rd_tmo_o, rd_err_o
    );

    modport master (
        output rd_req_i, rd_port_i, rd_mode_i, rd_tmo_i, rd_abort_i,
        input  busy_o, rd_ack_o, rd_data_o, rd_new_o, rd_tmo_o, rd_err_o
    );

endinterface

// File: rtl/qproc_inport_tmo.sv
// Loadable wait-timeout down-counter: expires when the count reaches 1,
// a loaded value of 0 never expires.
module qproc_inport_tmo #(
    parameter int TMO_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TMO_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expire_o
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // Next count: load wins over decrement; zero is sticky.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TMO_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == TMO_W'(1));

endmodule

// File: rtl/qproc_inport_rd.sv
// Core-side read engine: immediate or wait-for-new reads of one input port,
// returning the word with status flags and a clear pulse for consumed data.
module qproc_inport_rd
    import qproc_inport_pkg::*;
#(
    parameter int PORT_QTY = 2,
    parameter int TMO_W    = 16
) (
    input  logic                     c_clk_i,
    input  logic                     c_rst_i,
    input  logic [PORT_QTY-1:0]      port_tnew_i,
    input  logic [PORT_QTY-1:0][63:0] port_tdata_i,
    output logic [PORT_QTY-1:0]      port_clr_o,
    qproc_inport_rd_if.slave         rd
);

    localparam int LIM_W = PORT_IDX_W + 1;

    inrd_st_t              state_q, state_d;
    logic [PORT_IDX_W-1:0] port_q, port_d, sel_port_s;
    logic [63:0]           data_q, data_d, sel_data_s;
    inrd_flags_t           flags_q, flags_d;
    logic [PORT_QTY-1:0]   clr_q, clr_d, sel_hot_s;
    logic                  sel_new_s, sel_ok_s;
    logic                  tmo_load_s, tmo_dec_s, tmo_expire_s;

    // In IDLE the decision uses the live request port, afterwards the latched one.
    always_comb begin
        sel_port_s = (state_q == IDLE) ? rd.rd_port_i : port_q;
        sel_ok_s   = ({1'b0, sel_port_s} < LIM_W'(PORT_QTY));
        sel_hot_s  = '0;
        sel_data_s = 64'd0;
        for (int i = 0; i < PORT_QTY; i++) begin
            sel_hot_s[i] = (sel_port_s == PORT_IDX_W'(i));
            sel_data_s   = sel_data_s | ({64{sel_hot_s[i]}} & port_tdata_i[i]);
        end
        sel_new_s = |(sel_hot_s & port_tnew_i);
    end

    // Next-state and ack-content decision.
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        data_d     = data_q;
        flags_d    = flags_q;
        clr_d      = '0;
        tmo_load_s = 1'b0;
        tmo_dec_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd.rd_req_i) begin
                    port_d = rd.rd_port_i;
                    if (!sel_ok_s) begin
                        state_d = ACK;
                        data_d  = 64'd0;
                        flags_d = mk_flags(1'b0, 1'b0, 1'b1);
                    end else if (rd.rd_mode_i == INRD_WAIT) begin
                        state_d    = WAIT;
                        tmo_load_s = 1'b1;
                    end else begin
                        state_d = ACK;
                        data_d  = sel_data_s;
                        flags_d = mk_flags(sel_new_s, 1'b0, 1'b0);
                        clr_d   = sel_hot_s & {PORT_QTY{sel_new_s}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // Abort beats fresh data, which then stays unread.
                if (rd.rd_abort_i) begin
                    state_d = IDLE;
                end else if (sel_new_s) begin
                    state_d = ACK;
                    data_d  = sel_data_s;
                    flags_d = mk_flags(1'b1, 1'b0, 1'b0);
                    clr_d   = sel_hot_s;
                end else if (tmo_expire_s) begin
                    state_d = ACK;
                    data_d  = sel_data_s;
                    flags_d = mk_flags(1'b0, 1'b1, 1'b0);
                end else begin
                    tmo_dec_s = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and held response registers.
    always_ff @(posedge c_clk_i) begin
        if (c_rst_i) begin
            state_q <= IDLE;
            port_q  <= '0;
            data_q  <= 64'd0;
            flags_q <= mk_flags(1'b0, 1'b0, 1'b0);
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            clr_q   <= clr_d;
        end
    end

    qproc_inport_tmo #(
        .TMO_W (TMO_W)
    ) u_tmo (
        .clk_i      (c_clk_i),
        .rst_i      (c_rst_i),
        .load_i     (tmo_load_s),
        .load_val_i (rd.rd_tmo_i),
        .dec_i      (tmo_dec_s),
        .expire_o   (tmo_expire_s)
    );

    assign rd.busy_o    = (state_q != IDLE);
    assign rd.rd_ack_o  = (state_q == ACK);
    assign rd.rd_data_o = data_q;
    assign rd.rd_new_o  = flags_q.is_new;
    assign rd.rd_tmo_o  = flags_q.tmo;
    assign rd.rd_err_o  = flags_q.err;
    assign port_clr_o   = clr_q;

endmodule

// File: tb/tb_qproc_inport_rd.sv
// Self-checking bench for qproc_inport_rd with a cycle-level read model.
module tb_qproc_inport_rd;

    logic             clk;
    logic             rst;
    logic [1:0]       tnew;
    logic [1:0][63:0] tdata;
    logic [1:0]       clr;
    int               n_checks;
    int               n_pass;

    qproc_inport_rd_if #(.TMO_W(16)) rd_if ();

    qproc_inport_rd #(
        .PORT_QTY (2),
        .TMO_W    (16)
    ) dut (
        .c_clk_i      (clk),
        .c_rst_i      (rst),
        .port_tnew_i  (tnew),
        .port_tdata_i (tdata),
        .port_clr_o   (clr),
        .rd           (rd_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outcome of one read from the timing rules, cycle 0 = request cycle.
    task automatic model(input int p, input int m, input int n, input int new0, input int arrive,
                         input logic [63:0] d0, input logic [63:0] d1,
                         output int ack, output logic [63:0] d, output logic [2:0] f,
                         output logic [1:0] c);
        int w;
        if (p >= 2) begin
            ack = 1; d = 64'd0; f = 3'b001; c = 2'b00;
        end else if (m == 0) begin
            ack = 1; d = d0; f = {new0[0], 2'b00}; c = new0[0] ? (2'b01 << p) : 2'b00;
        end else begin
            w = (new0 != 0) ? 1 : ((arrive >= 1) ? arrive : 1000000);
            if (w < 1000000 && (n == 0 || w <= n)) begin
                ack = w + 1; d = (arrive >= 1 && w >= arrive) ? d1 : d0;
                f = 3'b100; c = 2'b01 << p;
            end else begin
                ack = n + 1; d = (arrive >= 1 && n >= arrive) ? d1 : d0;
                f = 3'b010; c = 2'b00;
            end
        end
    endtask

    // Issues one read in the current cycle and observes the response.
    task automatic run_read(input int p, input int m, input int n, input int arrive,
                            input logic [63:0] d1, input int abort_at,
                            output int ack_c, output int idle_c, output logic [63:0] d_o,
                            output logic [2:0] f_o, output logic [1:0] clr_o, output bit busy_ok);
        ack_c = -1; idle_c = -1; d_o = 64'd0; f_o = 3'b000; clr_o = 2'b00; busy_ok = 1'b1;
        if (rd_if.busy_o !== 1'b0) busy_ok = 1'b0;
        rd_if.rd_req_i  = 1'b1;
        rd_if.rd_port_i = 4'(p);
        rd_if.rd_mode_i = m[0];
        rd_if.rd_tmo_i  = 16'(n);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            rd_if.rd_req_i   = 1'b0;
            rd_if.rd_abort_i = (k == abort_at);
            clr_o = clr_o | clr;
            if (rd_if.rd_ack_o === 1'b1) begin
                ack_c = k;
                d_o   = rd_if.rd_data_o;
                f_o   = {rd_if.rd_new_o, rd_if.rd_tmo_o, rd_if.rd_err_o};
                if (rd_if.busy_o !== 1'b1) busy_ok = 1'b0;
                break;
            end
            if (abort_at >= 0 && k > abort_at && rd_if.busy_o === 1'b0) begin
                idle_c = k;
                break;
            end
            if (rd_if.busy_o !== 1'b1) busy_ok = 1'b0;
            if (k == arrive && p < 2) begin
                tnew[p] = 1'b1;
                tdata[p] = d1;
            end
        end
        rd_if.rd_abort_i = 1'b0;
        @(posedge clk); #1;
        if (rd_if.busy_o !== 1'b0 || rd_if.rd_ack_o !== 1'b0) busy_ok = 1'b0;
        tnew = tnew & ~clr_o;
    endtask

    task automatic test_reset;
        rd_if.rd_req_i = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++; if (rd_if.busy_o !== 1'b0) $display("FAIL rst_busy got %b exp 0", rd_if.busy_o); else n_pass++;
        n_checks++; if (rd_if.rd_ack_o !== 1'b0) $display("FAIL rst_ack got %b exp 0", rd_if.rd_ack_o); else n_pass++;
        n_checks++; if (clr !== 2'b00) $display("FAIL rst_clr got %b exp 00", clr); else n_pass++;
        n_checks++; if (rd_if.rd_data_o !== 64'd0) $display("FAIL rst_data got %h exp 0", rd_if.rd_data_o); else n_pass++;
        n_checks++; if ({rd_if.rd_new_o, rd_if.rd_tmo_o, rd_if.rd_err_o} !== 3'b000)
            $display("FAIL rst_flags got %b exp 000", {rd_if.rd_new_o, rd_if.rd_tmo_o, rd_if.rd_err_o}); else n_pass++;
        rst = 1'b0;
        rd_if.rd_req_i = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (rd_if.busy_o !== 1'b0) $display("FAIL rst_release_busy got %b exp 0", rd_if.busy_o); else n_pass++;
    endtask

    task automatic test_immediate;
        int a, ic; logic [63:0] d; logic [2:0] f; logic [1:0] c; bit b;
        tnew = 2'b10; tdata[1] = 64'hDEAD_BEEF_0000_0001; tdata[0] = {$urandom, $urandom};
        run_read(1, 0, 0, -1, 64'd0, -1, a, ic, d, f, c, b);
        n_checks++; if (a !== 1) $display("FAIL imm_ack_cyc got %0d exp 1", a); else n_pass++;
        n_checks++; if (d !== 64'hDEAD_BEEF_0000_0001) $display("FAIL imm_data got %h exp deadbeef00000001", d); else n_pass++;
        n_checks++; if (f !== 3'b100) $display("FAIL imm_flags got %b exp 100", f); else n_pass++;
        n_checks++; if (c !== 2'b10) $display("FAIL imm_clr got %b exp 10", c); else n_pass++;
        n_checks++; if (b !== 1'b1) $display("FAIL imm_busy got %b exp 1", b); else n_pass++;
        n_checks++; if (rd_if.rd_data_o !== 64'hDEAD_BEEF_0000_0001) $display("FAIL imm_hold got %h exp deadbeef00000001", rd_if.rd_data_o); else n_pass++;
        run_read(1, 0, 0, -1, 64'd0, -1, a, ic, d, f, c, b);
        n_checks++; if (a !== 1) $display("FAIL imm2_ack_cyc got %0d exp 1", a); else n_pass++;
        n_checks++; if (f !== 3'b000) $display("FAIL imm2_flags got %b exp 000", f); else n_pass++;
        n_checks++; if (c !== 2'b00) $display("FAIL imm2_clr got %b exp 00", c); else n_pass++;
    endtask

    task automatic test_wait_forever;
        int a, ic; logic [63:0] d, d1; logic [2:0] f; logic [1:0] c; bit b;
        tnew = 2'b00; d1 = {$urandom, $urandom};
        run_read(0, 1, 0, 7, d1, -1, a, ic, d, f, c, b);
        n_checks++; if (a !== 8) $display("FAIL wait_ack_cyc got %0d exp 8", a); else n_pass++;
        n_checks++; if (d !== d1) $display("FAIL wait_data got %h exp %h", d, d1); else n_pass++;
        n_checks++; if (f !== 3'b100) $display("FAIL wait_flags got %b exp 100", f); else n_pass++;
        n_checks++; if (c !== 2'b01) $display("FAIL wait_clr got %b exp 01", c); else n_pass++;
        n_checks++; if (b !== 1'b1) $display("FAIL wait_busy got %b exp 1", b); else n_pass++;
    endtask

    task automatic test_wait_timeout;
        int a, ic; logic [63:0] d, d0; logic [2:0] f; logic [1:0] c; bit b;
        tnew = 2'b00; d0 = {$urandom, $urandom}; tdata[1] = d0;
        run_read(1, 1, 5, -1, 64'd0, -1, a, ic, d, f, c, b);
        n_checks++; if (a !== 6) $display("FAIL tmo_ack_cyc got %0d exp 6", a); else n_pass++;
        n_checks++; if (f !== 3'b010) $display("FAIL tmo_flags got %b exp 010", f); else n_pass++;
        n_checks++; if (c !== 2'b00) $display("FAIL tmo_clr got %b exp 00", c); else n_pass++;
        n_checks++; if (b !== 1'b1) $display("FAIL tmo_busy got %b exp 1", b); else n_pass++;
        n_checks++; if (d !== d0) $display("FAIL tmo_data got %h exp %h", d, d0); else n_pass++;
    endtask

    task automatic test_abort;
        int a, ic; logic [63:0] d, d1; logic [2:0] f; logic [1:0] c; bit b;
        tnew = 2'b00; d1 = {$urandom, $urandom};
        run_read(0, 1, 0, 4, d1, 4, a, ic, d, f, c, b);
        n_checks++; if (a !== -1) $display("FAIL abort_ack got %0d exp -1", a); else n_pass++;
        n_checks++; if (ic !== 5) $display("FAIL abort_idle_cyc got %0d exp 5", ic); else n_pass++;
        n_checks++; if (c !== 2'b00) $display("FAIL abort_clr got %b exp 00", c); else n_pass++;
        run_read(0, 0, 0, -1, 64'd0, -1, a, ic, d, f, c, b);
        n_checks++; if (f !== 3'b100) $display("FAIL abort_still_new got %b exp 100", f); else n_pass++;
        n_checks++; if (d !== d1) $display("FAIL abort_data got %h exp %h", d, d1); else n_pass++;
    endtask

    task automatic test_bad_port;
        int a, ic; logic [63:0] d; logic [2:0] f; logic [1:0] c; bit b;
        int ports [2] = '{3, 15};
        foreach (ports[j]) begin
            tnew = 2'b11;
            run_read(ports[j], int'($urandom_range(0, 1)), 3, -1, 64'd0, -1, a, ic, d, f, c, b);
            n_checks++; if (a !== 1) $display("FAIL bad_ack_cyc port %0d got %0d exp 1", ports[j], a); else n_pass++;
            n_checks++; if (f !== 3'b001) $display("FAIL bad_flags port %0d got %b exp 001", ports[j], f); else n_pass++;
            n_checks++; if (d !== 64'd0) $display("FAIL bad_data port %0d got %h exp 0", ports[j], d); else n_pass++;
            n_checks++; if (c !== 2'b00) $display("FAIL bad_clr port %0d got %b exp 00", ports[j], c); else n_pass++;
        end
        tnew = 2'b00;
    endtask

    task automatic test_reset_mid_wait;
        int a, ic; logic [63:0] d; logic [2:0] f; logic [1:0] c; bit b;
        tnew = 2'b00;
        rd_if.rd_req_i = 1'b1; rd_if.rd_port_i = 4'd0; rd_if.rd_mode_i = 1'b1; rd_if.rd_tmo_i = 16'd0;
        @(posedge clk); #1;
        rd_if.rd_req_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if ({rd_if.busy_o, rd_if.rd_ack_o, clr} !== 4'b0000)
            $display("FAIL midrst_ctrl got %b exp 0000", {rd_if.busy_o, rd_if.rd_ack_o, clr}); else n_pass++;
        n_checks++; if (rd_if.rd_data_o !== 64'd0) $display("FAIL midrst_data got %h exp 0", rd_if.rd_data_o); else n_pass++;
        n_checks++; if ({rd_if.rd_new_o, rd_if.rd_tmo_o, rd_if.rd_err_o} !== 3'b000)
            $display("FAIL midrst_flags got %b exp 000", {rd_if.rd_new_o, rd_if.rd_tmo_o, rd_if.rd_err_o}); else n_pass++;
        tnew = 2'b10; tdata[1] = {$urandom, $urandom};
        run_read(1, 0, 0, -1, 64'd0, -1, a, ic, d, f, c, b);
        n_checks++; if (a !== 1) $display("FAIL midrst_imm_ack got %0d exp 1", a); else n_pass++;
        n_checks++; if (d !== tdata[1]) $display("FAIL midrst_imm_data got %h exp %h", d, tdata[1]); else n_pass++;
        n_checks++; if (f !== 3'b100 || c !== 2'b10) $display("FAIL midrst_imm_flags got %b/%b exp 100/10", f, c); else n_pass++;
    endtask

    task automatic test_random;
        int a, ic, ea, p, m, n, new0, arrive; logic [63:0] d, ed, d0, d1; logic [2:0] f, ef;
        logic [1:0] c, ec; bit b;
        for (int it = 0; it < 30; it++) begin
            p = int'($urandom_range(0, 3)); m = int'($urandom_range(0, 1));
            n = int'($urandom_range(0, 6)); arrive = int'($urandom_range(0, 9));
            if (arrive == 0) arrive = -1;
            tnew = 2'($urandom); tdata[0] = {$urandom, $urandom}; tdata[1] = {$urandom, $urandom};
            new0 = (p < 2) ? int'(tnew[p]) : 0;
            if (m == 1 && n == 0 && new0 == 0 && arrive < 1) arrive = int'($urandom_range(1, 8));
            d0 = (p < 2) ? tdata[p] : 64'd0;
            d1 = {$urandom, $urandom};
            model(p, m, n, new0, arrive, d0, d1, ea, ed, ef, ec);
            run_read(p, m, n, arrive, d1, -1, a, ic, d, f, c, b);
            n_checks++; if (a !== ea) $display("FAIL rnd%0d_ack_cyc got %0d exp %0d", it, a, ea); else n_pass++;
            n_checks++; if (d !== ed) $display("FAIL rnd%0d_data got %h exp %h", it, d, ed); else n_pass++;
            n_checks++; if (f !== ef) $display("FAIL rnd%0d_flags got %b exp %b", it, f, ef); else n_pass++;
            n_checks++; if (c !== ec) $display("FAIL rnd%0d_clr got %b exp %b", it, c, ec); else n_pass++;
            n_checks++; if (b !== 1'b1) $display("FAIL rnd%0d_busy got %b exp 1", it, b); else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1; tnew = 2'b00; tdata = '0;
        rd_if.rd_req_i = 1'b0; rd_if.rd_port_i = 4'd0; rd_if.rd_mode_i = 1'b0;
        rd_if.rd_tmo_i = 16'd0; rd_if.rd_abort_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        test_reset();
        test_immediate();
        test_wait_forever();
        test_wait_timeout();
        test_abort();
        test_bad_port();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
